time_entry: RTL
===============

TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 SHALL have parameter MAX_MIN, default 59, meaning the largest minute value accepted at commit.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port digit_valid  input  1  single-cycle strobe marking a keypad digit press (already synchronized and edge-detected upstream).
REQ-005 SHALL have port digit  input  4  binary digit value, sampled only when digit_valid=1.
REQ-006 SHALL have port enter  input  1  single-cycle commit request.
REQ-007 SHALL have port clear  input  1  single-cycle request to discard the entry buffer.
REQ-008 SHALL have port time_out  output  12  committed time packed {minute[5:0], second[5:0]}, binary.
REQ-009 SHALL have port time_valid  output  1  one-cycle pulse when time_out is updated.
REQ-010 SHALL have port error  output  1  one-cycle pulse on a rejected digit or rejected commit.
REQ-011 SHALL have port bcd_out  output  16  entry buffer {m1,m0,s1,s0}, 4 bits each, for display loopback.
REQ-012 SHALL have port count  output  3  number of digits currently in the buffer, 0..4.

Function
REQ-013 SHALL implement FSM states IDLE (count=0), ENTRY (count 1..4) and CHECK (one-cycle validation).
REQ-014 In IDLE or ENTRY, digit_valid with digit<=9 and count<4 SHALL shift the buffer left by one digit (m1<=m0, m0<=s1, s1<=s0, s0<=digit), increment count, and enter ENTRY.
REQ-015 digit_valid with digit>9 SHALL leave the buffer and count unchanged and pulse error for one cycle.
REQ-016 digit_valid with count=4 SHALL be ignored silently, with no shift and no error.
REQ-017 enter in ENTRY SHALL move the FSM to CHECK on the next edge; enter in IDLE SHALL be ignored.
REQ-018 In CHECK, minute SHALL be m1*10+m0 and second SHALL be s1*10+s0, each computed at 7-bit width before truncation to 6 bits.
REQ-019 In CHECK, if s1>5 or minute>MAX_MIN, the block SHALL pulse error, leave time_out unchanged, zero the buffer and count, and return to IDLE.
REQ-020 Otherwise the CHECK edge SHALL load time_out, pulse time_valid, zero the buffer and count, and return to IDLE.
REQ-021 Latency SHALL be: enter sampled at edge N, CHECK during cycle N..N+1, time_valid/error high for the cycle after edge N+1.
REQ-022 digit_valid, enter and clear SHALL be ignored while in CHECK.
REQ-023 Priority on simultaneous inputs SHALL be clear > enter > digit_valid; the lower-priority inputs are dropped.
REQ-024 clear SHALL zero the buffer and count, return the FSM to IDLE, and leave time_out unchanged, with no error.
REQ-025 time_valid and error SHALL never be asserted in the same cycle.
REQ-026 A partial entry SHALL be right-aligned: entering 4,5 then enter SHALL commit 00:45.

Reset
REQ-027 While n_rst=0, regardless of clk, the block SHALL hold the FSM in IDLE with time_out=0, time_valid=0, error=0, bcd_out=0 and count=0.
REQ-028 Deasserting n_rst mid-entry or during CHECK SHALL discard the entry and produce no pulse.

Verification
REQ-029 Digits 1,2,3,4 then enter -> time_out=12'b001100_100010 (12:34); time_valid is one cycle, two edges after enter.
REQ-030 Digits 9,9 then enter -> error pulse; time_out keeps its prior value; count=0.
REQ-031 Digits 7,5,0,0 then enter, MAX_MIN=59 -> error; with MAX_MIN=63 the same entry -> error (75>63), while 6,3,0,0 -> 63:00 valid.
REQ-032 Digit 0xA -> error pulse with bcd_out unchanged; a fifth digit after 1,2,3,4 -> ignored with bcd_out=16'h1234.
REQ-033 clear and enter in the same cycle with digits 1,2 -> count=0, no time_valid, no error.
REQ-034 n_rst pulled low asynchronously after digits 5,9 -> bcd_out=0 and count=0 immediately; time_out=0.

Source files
------------

// File: rtl/time_entry_if.sv
// Keypad time-entry bus: digit/enter/clear requests in, committed time and buffer view out.
interface time_entry_if;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        enter;
  logic        clear;
  logic [11:0] time_out;
  logic        time_valid;
  logic        error;
  logic [15:0] bcd_out;
  logic [2:0]  count;

  modport master (
    output digit_valid, digit, enter, clear,
    input  time_out, time_valid, error, bcd_out, count
  );

  modport slave (
    input  digit_valid, digit, enter, clear,
    output time_out, time_valid, error, bcd_out, count
  );
endinterface

// File: rtl/time_entry.sv
// Keypad mm:ss entry: shifts BCD digits into a 4-digit buffer, validates on enter,
// and commits a packed binary {minute, second} with a one-cycle valid or error pulse.
module time_entry #(
  parameter int unsigned MAX_MIN = 59
) (
  input logic         clk,
  input logic         n_rst,
  time_entry_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ENTRY, CHECK} state_t;

  state_t      state_q, state_n;
  logic [15:0] entry_q, entry_n;
  logic [2:0]  count_q, count_n;
  logic [11:0] tout_q, tout_n;
  logic        tv_q, tv_n;
  logic        err_q, err_n;

  logic [6:0]  minute, second;
  logic        bad_time;

  always_comb begin
    minute   = 7'(entry_q[15:12]) * 7'd10 + 7'(entry_q[11:8]);
    second   = 7'(entry_q[7:4]) * 7'd10 + 7'(entry_q[3:0]);
    bad_time = (entry_q[7:4] > 4'd5) || (minute > 7'(MAX_MIN));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      entry_q <= '0;
      count_q <= '0;
      tout_q  <= '0;
      tv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      entry_q <= entry_n;
      count_q <= count_n;
      tout_q  <= tout_n;
      tv_q    <= tv_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    entry_n = entry_q;
    count_n = count_q;
    tout_n  = tout_q;
    tv_n    = 1'b0;
    err_n   = 1'b0;
    unique case (state_q)
      IDLE, ENTRY: begin
        // clear > enter > digit; a losing request is dropped, not deferred
        if (bus.clear) begin
          entry_n = '0;
          count_n = '0;
          state_n = IDLE;
        end else if (bus.enter) begin
          if (state_q == ENTRY) state_n = CHECK;
        end else if (bus.digit_valid && count_q != 3'd4) begin
          if (bus.digit > 4'd9) begin
            err_n = 1'b1;
          end else begin
            entry_n = {entry_q[11:0], bus.digit};
            count_n = count_q + 3'd1;
            state_n = ENTRY;
          end
        end
      end
      CHECK: begin
        if (bad_time) begin
          err_n = 1'b1;
        end else begin
          tout_n = {minute[5:0], second[5:0]};
          tv_n   = 1'b1;
        end
        entry_n = '0;
        count_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.time_out   = tout_q;
  assign bus.time_valid = tv_q;
  assign bus.error      = err_q;
  assign bus.bcd_out    = entry_q;
  assign bus.count      = count_q;

endmodule
